// File: rtl/apb_ahb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_ahb_master_bridge
// Brief    : APB4 slave to AHB-Lite master bridge. One transfer in flight,
//            registered two-phase AHB master with wait-state handling and
//            AHB error propagation to PSLVERR.
//            Optional feature macro: APB_AHB_BRIDGE_NARROW_EN
//            (writes derive HSIZEM / HADDRM[1:0] from PSTRB).
// Revision : 1.0 - initial release
// ============================================================================
module apb_ahb_master_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HMASTER_ID = 4'h0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // APB4 slave side
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  // AHB-Lite master side
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic [3:0]            HMASTERM,
  output logic                  HMASTLOCKM,
  output logic [31:0]           HWDATAM,
  input  logic                  HREADYM,
  input  logic [31:0]           HRDATAM,
  input  logic                  HRESPM
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  state_t                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] haddr_q,   haddr_d;
  logic [1:0]            htrans_q,  htrans_d;
  logic                  hwrite_q,  hwrite_d;
  logic [2:0]            hsize_q,   hsize_d;
  logic [3:0]            hprot_q,   hprot_d;
  logic [31:0]           hwdata_q,  hwdata_d;
  logic [31:0]           prdata_q,  prdata_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;

  logic [2:0]            setup_size;
  logic [1:0]            setup_lo;
  logic                  unused_in;

`ifdef APB_AHB_BRIDGE_NARROW_EN
  // Map write strobes to an AHB size and byte offset; reads stay word-wide
  always_comb begin
    setup_size = HSIZE_WORD;
    setup_lo   = 2'b00;
    if (PWRITE) begin
      case (PSTRB)
        4'b0001: begin setup_size = HSIZE_BYTE; setup_lo = 2'd0; end
        4'b0010: begin setup_size = HSIZE_BYTE; setup_lo = 2'd1; end
        4'b0100: begin setup_size = HSIZE_BYTE; setup_lo = 2'd2; end
        4'b1000: begin setup_size = HSIZE_BYTE; setup_lo = 2'd3; end
        4'b0011: begin setup_size = HSIZE_HALF; setup_lo = 2'd0; end
        4'b1100: begin setup_size = HSIZE_HALF; setup_lo = 2'd2; end
        default: begin setup_size = HSIZE_WORD; setup_lo = 2'd0; end
      endcase
    end
  end
  assign unused_in = ^{PPROT[1], PADDR[1:0]};
`else
  // Full-word transfers only; strobes are not used
  always_comb begin
    setup_size = HSIZE_WORD;
    setup_lo   = 2'b00;
  end
  assign unused_in = ^{PPROT[1], PADDR[1:0], PSTRB};
`endif

  // Next-state and next-output computation for the transfer sequencer
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hprot_d   = hprot_q;
    hwdata_d  = hwdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = S_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = {PADDR[ADDR_WIDTH-1:2], setup_lo};
          hwrite_d = PWRITE;
          hsize_d  = setup_size;
          hprot_d  = {1'b1, 1'b1, PPROT[0], ~PPROT[2]};
          hwdata_d = PWDATA;
        end
      end
      S_ADDR: begin
        if (HREADYM) begin
          state_d  = S_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      S_DATA: begin
        if (HREADYM && !HRESPM) begin
          state_d  = S_RESP;
          pready_d = 1'b1;
          if (!hwrite_q) begin
            prdata_d = HRDATAM;
          end
        end else if (!HREADYM && HRESPM) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        // second cycle of the two-cycle AHB error response
        if (HREADYM) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = 32'h0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      hprot_q   <= 4'h0;
      hwdata_q  <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hprot_q   <= hprot_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign HADDRM     = haddr_q;
  assign HTRANSM    = htrans_q;
  assign HWRITEM    = hwrite_q;
  assign HSIZEM     = hsize_q;
  assign HPROTM     = hprot_q;
  assign HWDATAM    = hwdata_q;
  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign HBURSTM    = 3'b000;
  assign HMASTERM   = HMASTER_ID;
  assign HMASTLOCKM = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_apb_ahb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_ahb_master_bridge
// Brief    : Self-checking bench for apb_ahb_master_bridge. A transfer-level
//            model predicts cycle timing and AHB/APB values from the transfer
//            parameters (wait states, error, strobes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_ahb_master_bridge;

  localparam int AW = 32;
`ifdef APB_AHB_BRIDGE_NARROW_EN
  localparam bit NARROW = 1'b1;
`else
  localparam bit NARROW = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM, HBURSTM;
  logic [3:0]    HPROTM, HMASTERM;
  logic          HMASTLOCKM;
  logic [31:0]   HWDATAM;
  logic          HREADYM;
  logic [31:0]   HRDATAM;
  logic          HRESPM;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  apb_ahb_master_bridge #(.ADDR_WIDTH(AW), .HMASTER_ID(4'h0)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
    .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM),
    .HREADYM(HREADYM), .HRDATAM(HRDATAM), .HRESPM(HRESPM)
  );

  // Expected AHB size for a transfer, from the strobe rules
  function automatic logic [2:0] exp_size(input logic wr, input logic [3:0] strb);
    if (NARROW && wr && $countones(strb) == 1) return 3'b000;
    if (NARROW && wr && (strb == 4'b0011 || strb == 4'b1100)) return 3'b001;
    return 3'b010;
  endfunction

  // Expected byte offset for a transfer, from the strobe rules
  function automatic logic [1:0] exp_lo(input logic wr, input logic [3:0] strb);
    int idx;
    idx = 0;
    if (NARROW && wr && $countones(strb) == 1) idx = $clog2(strb);
    if (NARROW && wr && strb == 4'b1100) idx = 2;
    return idx[1:0];
  endfunction

  // One APB transfer with a scripted AHB slave; checks every cycle
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input int aw, input int dw, input bit err, input bit drop,
                      input logic [31:0] rdata, input string tag);
    int            ready_cyc;
    int            data_start;
    logic [31:0]   eaddr;
    logic [2:0]    esize;
    logic [3:0]    eprot;
    logic [31:0]   eprdata;
    ready_cyc  = 3 + aw + dw + (err ? 1 : 0);
    data_start = aw + 2;
    eaddr      = {addr[31:2], exp_lo(wr, strb)};
    esize      = exp_size(wr, strb);
    eprot      = {1'b1, 1'b1, prot[0], ~prot[2]};
    eprdata    = err ? 32'h0 : rdata;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
    HREADYM = 1'b1; HRESPM = 1'b0;
    @(posedge HCLK);
    for (int n = 1; n <= ready_cyc; n++) begin
      @(negedge HCLK);
      if (drop) begin PSEL = 1'b0; PENABLE = 1'b0; end
      else      begin PENABLE = 1'b1; end
      if (n < data_start) begin
        total++;
        if (HTRANSM !== 2'b10)
          begin bad++; $display("FAIL %s addr_htrans cyc%0d got=%b exp=10", tag, n, HTRANSM); end
        total++;
        if (HADDRM !== eaddr || HWRITEM !== wr || HSIZEM !== esize || HPROTM !== eprot) begin
          bad++;
          $display("FAIL %s addr_phase cyc%0d got addr=%h wr=%b size=%b prot=%b exp addr=%h wr=%b size=%b prot=%b",
                   tag, n, HADDRM, HWRITEM, HSIZEM, HPROTM, eaddr, wr, esize, eprot);
        end
        HREADYM = (n == data_start - 1);
        HRESPM  = 1'b0;
        HRDATAM = $urandom;
      end else if (n < ready_cyc) begin
        total++;
        if (HTRANSM !== 2'b00 || (wr && HWDATAM !== wdata)) begin
          bad++;
          $display("FAIL %s data_phase cyc%0d got trans=%b wdata=%h exp trans=00 wdata=%h",
                   tag, n, HTRANSM, HWDATAM, wdata);
        end
        HRDATAM = $urandom;
        if (!err) begin
          HREADYM = (n == ready_cyc - 1);
          HRESPM  = 1'b0;
          if (n == ready_cyc - 1) HRDATAM = rdata;
        end else begin
          HREADYM = (n == ready_cyc - 1);
          HRESPM  = (n >= ready_cyc - 2);
        end
      end
      if (n < ready_cyc) begin
        total++;
        if (PREADY !== 1'b0)
          begin bad++; $display("FAIL %s pready_early cyc%0d got=%b exp=0", tag, n, PREADY); end
      end
    end
    // response cycle
    total++;
    if (PREADY !== 1'b1 || PSLVERR !== err) begin
      bad++;
      $display("FAIL %s response cyc%0d got pready=%b pslverr=%b exp pready=1 pslverr=%b",
               tag, ready_cyc, PREADY, PSLVERR, err);
    end
    if (err || !wr) begin
      total++;
      if (PRDATA !== eprdata)
        begin bad++; $display("FAIL %s prdata got=%h exp=%h", tag, PRDATA, eprdata); end
    end
    PSEL = 1'b0; PENABLE = 1'b0; HREADYM = 1'b1; HRESPM = 1'b0;
    @(negedge HCLK);
    total++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || HTRANSM !== 2'b00) begin
      bad++;
      $display("FAIL %s after_resp got pready=%b pslverr=%b trans=%b exp 0 0 00",
               tag, PREADY, PSLVERR, HTRANSM);
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    total++;
    if (HTRANSM !== 2'b00 || HADDRM !== '0 || HWRITEM !== 1'b0 || HSIZEM !== 3'b010 || HWDATAM !== 32'h0) begin
      bad++;
      $display("FAIL reset_ahb got trans=%b addr=%h wr=%b size=%b wdata=%h exp 00 0 0 010 0",
               HTRANSM, HADDRM, HWRITEM, HSIZEM, HWDATAM);
    end
    total++;
    if (PRDATA !== 32'h0 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_apb got prdata=%h pready=%b pslverr=%b exp 0 0 0", PRDATA, PREADY, PSLVERR);
    end
    total++;
    if (HBURSTM !== 3'b000 || HMASTERM !== 4'h0 || HMASTLOCKM !== 1'b0) begin
      bad++;
      $display("FAIL reset_const got burst=%b master=%h lock=%b exp 000 0 0", HBURSTM, HMASTERM, HMASTLOCKM);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_word_write;
    xfer(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 1'b0, 1'b0, 32'h0, "word_write");
  endtask

  task automatic test_read_wait;
    xfer(1'b0, 32'h2000_0010, 32'h0, 4'h0, 3'b001, 0, 3, 1'b0, 1'b0, 32'h1234_5678, "read_wait3");
  endtask

  task automatic test_error;
    xfer(1'b0, 32'h4000_0000, 32'h0, 4'h0, 3'b100, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, "error_read");
    xfer(1'b1, 32'h4000_0008, 32'hA5A5_5A5A, 4'hF, 3'b000, 1, 2, 1'b1, 1'b0, 32'h0, "error_write");
  endtask

  task automatic test_narrow;
    xfer(1'b1, 32'h0000_0100, 32'h00AB_0000, 4'b0100, 3'b000, 0, 0, 1'b0, 1'b0, 32'h0, "narrow_byte2");
    xfer(1'b1, 32'h0000_0200, 32'hBEEF_0000, 4'b1100, 3'b000, 0, 0, 1'b0, 1'b0, 32'h0, "narrow_half2");
    xfer(1'b0, 32'h0000_0300, 32'h0, 4'b0001, 3'b000, 0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, "narrow_read");
  endtask

  task automatic test_addr_stall;
    xfer(1'b0, 32'h2000_0020, 32'h0, 4'hF, 3'b101, 2, 0, 1'b0, 1'b0, 32'h0BAD_CAFE, "addr_stall");
  endtask

  task automatic test_psel_drop;
    xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 3'b000, 1, 1, 1'b0, 1'b1, 32'h7777_1111, "psel_drop");
  endtask

  task automatic test_reset_mid;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h3000_0000;
    PWDATA = 32'h0; PSTRB = 4'hF; PPROT = 3'b000; HREADYM = 1'b1; HRESPM = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);            // address phase
    PENABLE = 1'b1; HREADYM = 1'b1;
    @(negedge HCLK);            // data phase, slave stalls, reset hits
    HREADYM = 1'b0; HRESET = 1'b1;
    @(negedge HCLK);
    total++;
    if (HTRANSM !== 2'b00 || PREADY !== 1'b0 || HADDRM !== '0 || HSIZEM !== 3'b010) begin
      bad++;
      $display("FAIL reset_mid got trans=%b pready=%b addr=%h size=%b exp 00 0 0 010",
               HTRANSM, PREADY, HADDRM, HSIZEM);
    end
    HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; HREADYM = 1'b1;
    xfer(1'b1, 32'h3000_0004, 32'h1357_9BDF, 4'hF, 3'b000, 0, 1, 1'b0, 1'b0, 32'h0, "after_reset");
  endtask

  task automatic test_random;
    logic [3:0] strb_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0011, 4'b1100, 4'b1111, 4'b0000};
    for (int i = 0; i < 24; i++) begin
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      bit          err;
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom;
      strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : strb_tab[$urandom_range(0, 7)];
      err  = ($urandom_range(0, 3) == 0);
      xfer(wr, addr, $urandom, strb, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
           err, ($urandom_range(0, 7) == 0), $urandom, "random");
    end
  endtask

  initial begin
    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'b000;
    HREADYM = 1'b1; HRDATAM = 32'h0; HRESPM = 1'b0;
    test_reset();
    test_word_write();
    test_read_wait();
    test_error();
    test_narrow();
    test_addr_stall();
    test_psel_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
